sa_ctrl: RTL

Sequencing controller for the weight-stationary systolic array `sa_top`. It accepts B-matrix rows and A-matrix rows on valid/ready streams, buffers B, and replays B into the array in reverse row order with `we` asserted. It then streams A rows, passing source bubbles through as idle cycles, and returns C rows on an output stream with a last flag. It sits between the matrix source/sink and `sa_top`, and owns the whole load/compute/drain sequence.

---
 rtl/sa_pkg.sv | 13 +
 rtl/sa_b_buf.sv | 34 +++
 rtl/sa_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared types and default dimensions for the systolic array controller and array.
package sa_pkg;
  localparam int SA_WIDTH = 16;
  localparam int SA_SIZE  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_B,
    ST_PUSH_B,
    ST_STREAM_A,
    ST_DRAIN
  } sa_ctrl_state_e;
endpackage

// File: rtl/sa_b_buf.sv
// B-matrix row buffer: sequential write by row index, read addressed from the
// last row backwards so the controller can replay rows in reverse order.
module sa_b_buf #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 3,
  parameter int CW    = $clog2(SIZE + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [CW-1:0]               waddr,
  input  logic [SIZE-1:0][WIDTH-1:0]  wdata,
  input  logic [CW-1:0]               rsel,
  output logic [SIZE-1:0][WIDTH-1:0]  rdata
);
  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] mem;

  // Row storage, one slot per B row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++)
        if (we && waddr == CW'(i)) mem[i] <= wdata;
    end
  end

  // rsel = k returns row SIZE-1-k; out-of-range selects read zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < SIZE; i++)
      if (rsel == CW'(SIZE - 1 - i)) rdata = mem[i];
  end
endmodule

// File: rtl/sa_ctrl.sv
// Load/push/stream/drain sequencer for the weight-stationary systolic array.
// All array-facing outputs and the C stream are registered; ready outputs
// are decoded from state only.
module sa_ctrl
  import sa_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH,
  parameter int SIZE  = SA_SIZE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic                        i_reuse_b,
  output logic                        o_busy,
  output logic                        o_done,
  input  logic                        s_b_vld,
  output logic                        s_b_rdy,
  input  logic [SIZE-1:0][WIDTH-1:0]  s_b_row,
  input  logic                        s_a_vld,
  output logic                        s_a_rdy,
  input  logic [SIZE-1:0][WIDTH-1:0]  s_a_row,
  output logic                        sa_we,
  output logic                        sa_a_vld,
  output logic                        sa_c_vld,
  output logic [SIZE-1:0][WIDTH-1:0]  sa_a_rows,
  input  logic                        sa_o_c_vld,
  input  logic [SIZE-1:0][WIDTH-1:0]  sa_o_c_rows,
  output logic                        m_c_vld,
  output logic [SIZE-1:0][WIDTH-1:0]  m_c_row,
  output logic                        m_c_last
);
  localparam int            CW   = $clog2(SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] FULL = CW'(SIZE);

  sa_ctrl_state_e state, state_nxt;
  logic [CW-1:0]  b_cnt, p_cnt, a_cnt, c_cnt;
  logic           b_resident;
  logic           b_hs, a_hs, c_cap;
  logic           we_nxt, a_vld_nxt, c_vld_nxt;
  logic [SIZE-1:0][WIDTH-1:0] rows_nxt, buf_rdata;

  assign s_b_rdy = (state == ST_LOAD_B);
  assign s_a_rdy = (state == ST_STREAM_A);
  assign o_busy  = (state != ST_IDLE);
  assign b_hs    = s_b_rdy && s_b_vld;
  assign a_hs    = s_a_rdy && s_a_vld;
  assign c_cap   = sa_o_c_vld && (state == ST_STREAM_A || state == ST_DRAIN);

  sa_b_buf #(.WIDTH(WIDTH), .SIZE(SIZE), .CW(CW)) u_b_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (b_hs),
    .waddr (b_cnt),
    .wdata (s_b_row),
    .rsel  (p_cnt),
    .rdata (buf_rdata)
  );

  // Next state and next values of the registered array-side outputs.
  always_comb begin
    state_nxt = state;
    we_nxt    = 1'b0;
    a_vld_nxt = 1'b0;
    c_vld_nxt = 1'b0;
    rows_nxt  = '0;
    case (state)
      ST_IDLE:
        if (i_start) state_nxt = (i_reuse_b && b_resident) ? ST_STREAM_A : ST_LOAD_B;
      ST_LOAD_B:
        if (b_hs && b_cnt == LAST) state_nxt = ST_PUSH_B;
      ST_PUSH_B: begin
        we_nxt    = 1'b1;
        a_vld_nxt = 1'b1;
        rows_nxt  = buf_rdata;
        if (p_cnt == LAST) state_nxt = ST_STREAM_A;
      end
      ST_STREAM_A: begin
        a_vld_nxt = s_a_vld;
        c_vld_nxt = s_a_vld;
        if (s_a_vld) rows_nxt = s_a_row;
        if (a_hs && a_cnt == LAST) state_nxt = ST_DRAIN;
      end
      ST_DRAIN:
        if (c_cnt == FULL) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counters (cleared on entry to their phase) and B residency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      b_cnt      <= '0;
      p_cnt      <= '0;
      a_cnt      <= '0;
      c_cnt      <= '0;
      b_resident <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_LOAD_B && state != ST_LOAD_B) b_cnt <= '0;
      else if (b_hs)                                  b_cnt <= b_cnt + CW'(1);
      if (state_nxt == ST_PUSH_B && state != ST_PUSH_B) p_cnt <= '0;
      else if (state == ST_PUSH_B)                    p_cnt <= p_cnt + CW'(1);
      if (state_nxt == ST_STREAM_A && state != ST_STREAM_A) begin
        a_cnt <= '0;
        c_cnt <= '0;
      end else begin
        if (a_hs)  a_cnt <= a_cnt + CW'(1);
        if (c_cap) c_cnt <= c_cnt + CW'(1);
      end
      if (state == ST_PUSH_B && p_cnt == LAST) b_resident <= 1'b1;
    end
  end

  // Registered array drive, C capture stage and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_we     <= 1'b0;
      sa_a_vld  <= 1'b0;
      sa_c_vld  <= 1'b0;
      sa_a_rows <= '0;
      m_c_vld   <= 1'b0;
      m_c_row   <= '0;
      m_c_last  <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      sa_we     <= we_nxt;
      sa_a_vld  <= a_vld_nxt;
      sa_c_vld  <= c_vld_nxt;
      sa_a_rows <= rows_nxt;
      m_c_vld   <= c_cap;
      m_c_last  <= c_cap && (c_cnt == LAST);
      if (c_cap) m_c_row <= sa_o_c_rows;
      o_done    <= (state == ST_DRAIN) && (c_cnt == FULL);
    end
  end
endmodule
